// File: rtl/kr_pkg.sv
// Shared constants and types for the Knight-Rider LED scanner.
// PWM resolution, duty levels, default sweep periods and the sweep direction type.
package kr_pkg;

  localparam int PWM_BITS            = 3;
  localparam int DUTY_BITS           = PWM_BITS + 1;
  localparam int DUTY_FULL           = 8;
  localparam int DUTY_HALF           = 4;
  localparam int DEFAULT_SLOW_PERIOD = 1024;
  localparam int DEFAULT_FAST_PERIOD = 256;
  localparam int IO_WIDTH            = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // An LED lit by several sources shows the brightest of them.
  function automatic logic [DUTY_BITS-1:0] duty_max(input logic [DUTY_BITS-1:0] a,
                                                    input logic [DUTY_BITS-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kr_step_timer.sv
// Head-step timer: counts clocks against the currently selected period and
// raises a one-cycle step pulse on the last clock of each period.
module kr_step_timer #(
  parameter int SLOW_PERIOD = 1024,
  parameter int FAST_PERIOD = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rate_ctrl,
  output logic o_step_pulse
);

  localparam int MAX_PERIOD = (SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD : FAST_PERIOD;
  localparam int CNT_W      = (MAX_PERIOD > 2) ? $clog2(MAX_PERIOD) : 1;

  localparam logic [CNT_W-1:0] SLOW_LIMIT = CNT_W'(SLOW_PERIOD - 1);
  localparam logic [CNT_W-1:0] FAST_LIMIT = CNT_W'(FAST_PERIOD - 1);

  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] w_limit;
  logic             w_step;

  // ">=" rather than "==" so a switch to the short period with the count
  // already beyond its limit steps on the very next clock.
  assign w_limit = i_rate_ctrl ? FAST_LIMIT : SLOW_LIMIT;
  assign w_step  = (r_step_cnt >= w_limit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step_cnt <= '0;
    end else if (w_step) begin
      r_step_cnt <= '0;
    end else begin
      r_step_cnt <= r_step_cnt + CNT_W'(1);
    end
  end

  assign o_step_pulse = w_step;

endmodule

// File: rtl/knight_rider_kolos_koblasz.sv
// Knight-Rider scanner on an 8-in/8-out pin wrapper: a bouncing head LED with
// two PWM-dimmed trailing LEDs, selectable sweep speed and head brightness.
module knight_rider_kolos_koblasz
  import kr_pkg::*;
#(
  parameter int OUT_WIDTH   = 8,
  parameter int SLOW_PERIOD = DEFAULT_SLOW_PERIOD,
  parameter int FAST_PERIOD = DEFAULT_FAST_PERIOD
) (
  input  logic [IO_WIDTH-1:0] io_in,
  output logic [IO_WIDTH-1:0] io_out
);

  localparam int              POS_W    = $clog2(OUT_WIDTH);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(OUT_WIDTH - 1);

  logic w_clk;
  logic w_rst_n;
  logic w_rate_ctrl;
  logic w_brightness_ctrl;
  logic w_unused;
  logic w_step;

  assign w_clk             = io_in[0];
  assign w_rst_n           = io_in[1];
  assign w_rate_ctrl       = io_in[2];
  assign w_brightness_ctrl = io_in[3];
  assign w_unused          = &{1'b0, io_in[7:4]};

  logic [POS_W-1:0]    r_pos;
  logic [POS_W-1:0]    r_trail1;
  logic [POS_W-1:0]    r_trail2;
  dir_t                r_dir;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [IO_WIDTH-1:0] r_leds;

  logic [POS_W-1:0]     w_pos_nxt;
  logic [POS_W-1:0]     w_trail1_nxt;
  logic [POS_W-1:0]     w_trail2_nxt;
  dir_t                 w_dir_nxt;
  logic [IO_WIDTH-1:0]  w_leds_nxt;
  logic [DUTY_BITS-1:0] w_duty_head;
  logic [DUTY_BITS-1:0] w_duty_trail1;
  logic [DUTY_BITS-1:0] w_duty_trail2;
  logic [DUTY_BITS-1:0] w_duty [OUT_WIDTH];

  kr_step_timer #(
    .SLOW_PERIOD(SLOW_PERIOD),
    .FAST_PERIOD(FAST_PERIOD)
  ) u_step_timer (
    .i_clk       (w_clk),
    .i_rst_n     (w_rst_n),
    .i_rate_ctrl (w_rate_ctrl),
    .o_step_pulse(w_step)
  );

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pos     <= '0;
      r_dir     <= DIR_UP;
      r_trail1  <= '0;
      r_trail2  <= '0;
      r_pwm_cnt <= '0;
      r_leds    <= '0;
    end else begin
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_trail1  <= w_trail1_nxt;
      r_trail2  <= w_trail2_nxt;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_leds    <= w_leds_nxt;
    end
  end

  // Direction flips on the step that lands on an end LED, so ends are not repeated.
  always_comb begin
    w_pos_nxt    = r_pos;
    w_dir_nxt    = r_dir;
    w_trail1_nxt = r_trail1;
    w_trail2_nxt = r_trail2;
    if (w_step) begin
      w_trail2_nxt = r_trail1;
      w_trail1_nxt = r_pos;
      case (r_dir)
        DIR_UP: begin
          w_pos_nxt = r_pos + POS_W'(1);
          if (w_pos_nxt == POS_LAST) begin
            w_dir_nxt = DIR_DOWN;
          end
        end
        DIR_DOWN: begin
          w_pos_nxt = r_pos - POS_W'(1);
          if (w_pos_nxt == '0) begin
            w_dir_nxt = DIR_UP;
          end
        end
      endcase
    end
  end

  assign w_duty_head   = w_brightness_ctrl ? DUTY_BITS'(DUTY_FULL) : DUTY_BITS'(DUTY_HALF);
  assign w_duty_trail1 = w_duty_head >> 1;
  assign w_duty_trail2 = w_duty_head >> 2;

  // Duty map and PWM compare; LEDs beyond OUT_WIDTH stay dark.
  always_comb begin
    w_duty     = '{default: '0};
    w_leds_nxt = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (r_trail2 == POS_W'(i)) begin
        w_duty[i] = duty_max(w_duty[i], w_duty_trail2);
      end
      if (r_trail1 == POS_W'(i)) begin
        w_duty[i] = duty_max(w_duty[i], w_duty_trail1);
      end
      if (r_pos == POS_W'(i)) begin
        w_duty[i] = duty_max(w_duty[i], w_duty_head);
      end
      w_leds_nxt[i] = ({1'b0, r_pwm_cnt} < w_duty[i]);
    end
  end

  assign io_out = r_leds;

endmodule

// File: tb/tb_knight_rider_kolos_koblasz.sv
// Self-checking bench: a step-count based reference model predicts io_out every
// clock while scenario tasks drive rate/brightness/reset, partly at random.
module tb_knight_rider_kolos_koblasz;

  localparam int W    = 8;
  localparam int CYC  = 2 * (W - 1);
  localparam int SLOW = 1024;
  localparam int FAST = 256;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rate   = 1'b0;
  logic       bright = 1'b0;
  logic [3:0] junk   = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int checks   = 0;
  int failures = 0;

  assign io_in = {junk, bright, rate, rst_n, clk};

  knight_rider_kolos_koblasz #(
    .OUT_WIDTH  (W),
    .SLOW_PERIOD(SLOW),
    .FAST_PERIOD(FAST)
  ) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  // Reference model: position is a pure function of the number of steps taken.
  int         mSteps    = 0;
  int         mCnt      = 0;
  int         mPwm      = 0;
  int         mOutSteps = 0;
  int         mD, mH, mT1, mT2, mDuty;
  logic [7:0] mExp      = 8'h00;

  function automatic int posOf(input int s);
    int r;
    r = s % CYC;
    return (r <= W - 1) ? r : CYC - r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mSteps = 0; mCnt = 0; mPwm = 0; mOutSteps = 0; mExp = 8'h00;
    end else begin
      mD  = bright ? 8 : 4;
      mH  = posOf(mSteps);
      mT1 = posOf((mSteps > 0) ? mSteps - 1 : 0);
      mT2 = posOf((mSteps > 1) ? mSteps - 2 : 0);
      for (int i = 0; i < 8; i++) begin
        mDuty = 0;
        if (i == mT2) mDuty = mD / 4;
        if (i == mT1 && mD / 2 > mDuty) mDuty = mD / 2;
        if (i == mH) mDuty = mD;
        mExp[i] = (mPwm < mDuty);
      end
      mOutSteps = mSteps;
      if (mCnt >= (rate ? FAST : SLOW) - 1) begin
        mCnt = 0;
        mSteps++;
      end else begin
        mCnt++;
      end
      mPwm = (mPwm + 1) % 8;
    end
  end

  task automatic test_reset();
    logic [7:0] want;
    rst_n = 1'b0; rate = 1'b0; bright = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (io_out !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_hold io_out=%b expected=%b", io_out, 8'h00);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      want = {7'b0, ((c % 8) < 4) ? 1'b1 : 1'b0};
      checks++;
      if (io_out !== want) begin
        failures++;
        $display("[TB] FAIL reset_led0 c=%0d io_out=%b expected=%b", c, io_out, want);
      end
      checks++;
      if (io_out !== mExp) begin
        failures++;
        $display("[TB] FAIL reset_model c=%0d io_out=%b expected=%b", c, io_out, mExp);
      end
    end
  endtask

  task automatic test_sweep();
    int  target;
    bit  done = 0;
    rate = 1'b1; bright = 1'b1;
    target = mSteps + 15;
    for (int c = 0; c < 16 * FAST + 300; c++) begin
      @(negedge clk);
      checks++;
      if (io_out !== mExp) begin
        failures++;
        if (failures <= 30) $display("[TB] FAIL sweep c=%0d io_out=%b expected=%b", c, io_out, mExp);
      end
      checks++;
      if (io_out[posOf(mOutSteps)] !== 1'b1) begin
        failures++;
        if (failures <= 30) $display("[TB] FAIL sweep_head step=%0d io_out=%b expected head %0d on", mOutSteps, io_out, posOf(mOutSteps));
      end
      if (mOutSteps % CYC == 8) begin
        checks++;
        if (io_out[6] !== 1'b1 || io_out[7] !== (((mPwm + 7) % 8) < 4)) begin
          failures++;
          if (failures <= 30) $display("[TB] FAIL bounce io_out=%b expected LED6 on, LED7 half duty", io_out);
        end
      end
      if (mSteps >= target) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL sweep_timeout steps=%0d expected=%0d", mSteps, target);
    end
  endtask

  task automatic test_slow_rate();
    int target;
    bit done = 0;
    rate = 1'b0; bright = 1'b0;
    target = mSteps + 2;
    for (int c = 0; c < 2 * SLOW + 300; c++) begin
      @(negedge clk);
      checks++;
      if (io_out !== mExp) begin
        failures++;
        if (failures <= 30) $display("[TB] FAIL slow c=%0d io_out=%b expected=%b", c, io_out, mExp);
      end
      if (mSteps >= target) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL slow_timeout steps=%0d expected=%0d", mSteps, target);
    end
    done = 0;
    for (int c = 0; c < SLOW + 100; c++) begin
      @(negedge clk);
      checks++;
      if (io_out !== mExp) begin
        failures++;
        if (failures <= 30) $display("[TB] FAIL slow_wait c=%0d io_out=%b expected=%b", c, io_out, mExp);
      end
      if (mCnt == 600) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL switch_timeout cnt=%0d expected=600", mCnt);
    end
    rate = 1'b1;
    for (int c = 0; c < 3 * FAST + 10; c++) begin
      @(negedge clk);
      checks++;
      if (io_out !== mExp) begin
        failures++;
        if (failures <= 30) $display("[TB] FAIL rate_switch c=%0d io_out=%b expected=%b", c, io_out, mExp);
      end
    end
  endtask

  task automatic test_brightness();
    rate = 1'b1; bright = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (io_out !== mExp) begin
        failures++;
        if (failures <= 30) $display("[TB] FAIL brightness c=%0d io_out=%b expected=%b", c, io_out, mExp);
      end
      if ($urandom_range(0, 31) == 0) bright = ~bright;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if (io_out !== mExp) begin
        failures++;
        if (failures <= 30) $display("[TB] FAIL random c=%0d io_out=%b expected=%b", c, io_out, mExp);
      end
      junk = 4'($urandom);
      if ($urandom_range(0, 19) == 0) bright = ~bright;
      if ($urandom_range(0, 299) == 0) rate = ~rate;
    end
    junk = 4'h0;
  endtask

  task automatic test_async_reset();
    int wait_cyc;
    rate = 1'b1; bright = 1'b1;
    wait_cyc = $urandom_range(50, 600);
    for (int c = 0; c < wait_cyc; c++) begin
      @(negedge clk);
      checks++;
      if (io_out !== mExp) begin
        failures++;
        if (failures <= 30) $display("[TB] FAIL pre_reset c=%0d io_out=%b expected=%b", c, io_out, mExp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (io_out !== 8'h00) begin
      failures++;
      $display("[TB] FAIL async_reset_immediate io_out=%b expected=%b", io_out, 8'h00);
    end
    bright = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (io_out !== 8'h00) begin
        failures++;
        $display("[TB] FAIL async_reset_hold io_out=%b expected=%b", io_out, 8'h00);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < FAST + 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (io_out !== 8'h01) begin
          failures++;
          $display("[TB] FAIL restart_led0 io_out=%b expected=%b", io_out, 8'h01);
        end
      end
      checks++;
      if (io_out !== mExp) begin
        failures++;
        if (failures <= 30) $display("[TB] FAIL restart c=%0d io_out=%b expected=%b", c, io_out, mExp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_slow_rate();
    test_brightness();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
